// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the DDR3 controller: one request slot per port,
// round-robin or A-first grant, address/data held for the whole transaction.
module mem_arbiter #(
    parameter bit          PRIO = 1'b0,
    parameter int unsigned AW   = 20,
    localparam int unsigned DW  = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memreset,
    input  logic          areq,
    input  logic          awr,
    input  logic [AW-1:0] aaddr,
    input  logic [DW-1:0] awdata,
    output logic          aack,
    output logic [DW-1:0] ardata,
    output logic          abusy,
    output logic          aerr,
    input  logic          breq,
    input  logic          bwr,
    input  logic [AW-1:0] baddr,
    input  logic [DW-1:0] bwdata,
    output logic          back,
    output logic [DW-1:0] brdata,
    output logic          bbusy,
    output logic          berr,
    output logic [AW-1:0] memaddr,
    output logic          memwr,
    output logic [DW-1:0] memwdata,
    output logic          memreq,
    input  logic          memack,
    input  logic [DW-1:0] memrdata
);

    localparam logic [1:0] S_INIT = 2'd0;
    localparam logic [1:0] S_IDLE = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]    state, state_nxt;
    logic          awr_q, bwr_q;
    logic [AW-1:0] aaddr_q, baddr_q;
    logic [DW-1:0] awdata_q, bwdata_q;
    // Port of the current/most recent grant; doubles as the round-robin pointer.
    logic          gnt_b;
    logic          grant_c, pick_b_c, done_c;

    always_ff @(posedge clk or posedge reset) begin : state_reg
        if (reset) state <= S_INIT;
        else       state <= state_nxt;
    end

    always_comb begin : next_state
        state_nxt = state;
        grant_c   = 1'b0;
        done_c    = 1'b0;
        pick_b_c  = 1'b0;
        if (PRIO) pick_b_c = !abusy;
        else      pick_b_c = (abusy && bbusy) ? !gnt_b : bbusy;
        case (state)
            S_INIT: if (!memreset) state_nxt = S_IDLE;
            S_IDLE: begin
                if (memreset) begin
                    state_nxt = S_INIT;
                end else if (abusy || bbusy) begin
                    grant_c   = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (memack) begin
                    done_c    = 1'b1;
                    state_nxt = memreset ? S_INIT : S_IDLE;
                end
            end
            default: state_nxt = S_INIT;
        endcase
    end

    // Port A slot: a request is only accepted while the slot is free.
    always_ff @(posedge clk or posedge reset) begin : slot_a
        if (reset) begin
            abusy    <= 1'b0;
            aerr     <= 1'b0;
            awr_q    <= 1'b0;
            aaddr_q  <= '0;
            awdata_q <= '0;
        end else begin
            if (areq) begin
                if (abusy) begin
                    aerr <= 1'b1;
                end else begin
                    abusy    <= 1'b1;
                    awr_q    <= awr;
                    aaddr_q  <= aaddr;
                    awdata_q <= awdata;
                end
            end
            if (done_c && !gnt_b) abusy <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin : slot_b
        if (reset) begin
            bbusy    <= 1'b0;
            berr     <= 1'b0;
            bwr_q    <= 1'b0;
            baddr_q  <= '0;
            bwdata_q <= '0;
        end else begin
            if (breq) begin
                if (bbusy) begin
                    berr <= 1'b1;
                end else begin
                    bbusy    <= 1'b1;
                    bwr_q    <= bwr;
                    baddr_q  <= baddr;
                    bwdata_q <= bwdata;
                end
            end
            if (done_c && gnt_b) bbusy <= 1'b0;
        end
    end

    // Controller-side request and completion routing back to the granted port.
    always_ff @(posedge clk or posedge reset) begin : resp
        if (reset) begin
            memreq   <= 1'b0;
            memaddr  <= '0;
            memwr    <= 1'b0;
            memwdata <= '0;
            aack     <= 1'b0;
            back     <= 1'b0;
            ardata   <= '0;
            brdata   <= '0;
            gnt_b    <= 1'b1;
        end else begin
            memreq <= grant_c;
            aack   <= done_c && !gnt_b;
            back   <= done_c && gnt_b;
            if (grant_c) begin
                gnt_b    <= pick_b_c;
                memaddr  <= pick_b_c ? baddr_q  : aaddr_q;
                memwr    <= pick_b_c ? bwr_q    : awr_q;
                memwdata <= pick_b_c ? bwdata_q : awdata_q;
            end
            if (done_c && !gnt_b && !awr_q) ardata <= memrdata;
            if (done_c && gnt_b && !bwr_q)  brdata <= memrdata;
        end
    end

endmodule
